// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode map and result record for the integer ALU
package alu_pkg;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd16;
    localparam logic [5:0] OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_ADD   = 6'd20;
    localparam logic [5:0] OP_SUB   = 6'd21;
    localparam logic [5:0] OP_SLL   = 6'd22;
    localparam logic [5:0] OP_SLT   = 6'd23;
    localparam logic [5:0] OP_SLTU  = 6'd24;
    localparam logic [5:0] OP_XOR   = 6'd25;
    localparam logic [5:0] OP_SRL   = 6'd26;
    localparam logic [5:0] OP_SRA   = 6'd27;
    localparam logic [5:0] OP_OR    = 6'd28;
    localparam logic [5:0] OP_AND   = 6'd29;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic        jump;
        logic [31:0] target;
    } alu_result_t;

    // Codes 0 and 30..63 carry no work and must not raise a broadcast.
    function automatic logic op_supported(input logic [5:0] op);
        return (op >= OP_LUI) && (op <= OP_AND);
    endfunction

    // I-type ops take their second operand from the immediate.
    function automatic logic op_uses_imm(input logic [5:0] op);
        return (op >= OP_ADDI) && (op <= OP_SRAI);
    endfunction

endpackage

// File: rtl/alu_branch_cmp.sv
// rtl/alu_branch_cmp.sv - combinational branch condition evaluator
module branch_cmp
    import alu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    output logic        taken
);

    // Evaluate the branch condition; non-branch opcodes never report taken.
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = (val1 == val2);
            OP_BNE:  taken = (val1 != val2);
            OP_BLT:  taken = ($signed(val1) <  $signed(val2));
            OP_BGE:  taken = ($signed(val1) >= $signed(val2));
            OP_BLTU: taken = (val1 <  val2);
            OP_BGEU: taken = (val1 >= val2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle integer execution unit with registered broadcast
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [5:0]  alu_opcode,
    input  logic [31:0] alu_val1,
    input  logic [31:0] alu_val2,
    input  logic [31:0] alu_imm,
    input  logic [31:0] alu_pc,
    input  logic [5:0]  alu_rob_index,
    output logic        alu_valid,
    output logic [31:0] alu_res,
    output logic [5:0]  alu_rob_index_out,
    output logic        alu_jump,
    output logic [31:0] alu_target_pc
);

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic        br_taken;
    alu_result_t nxt;

    assign op2         = op_uses_imm(alu_opcode) ? alu_imm : alu_val2;
    assign shamt       = op2[4:0];
    assign pc_plus4    = alu_pc + 32'd4;
    assign pc_plus_imm = alu_pc + alu_imm;

    branch_cmp u_branch_cmp (
        .opcode (alu_opcode),
        .val1   (alu_val1),
        .val2   (alu_val2),
        .taken  (br_taken)
    );

    // Result mux: value, control-transfer decision and next PC for this op.
    always_comb begin
        nxt       = '0;
        nxt.valid = op_supported(alu_opcode);
        case (alu_opcode)
            OP_LUI:   nxt.res = alu_imm;
            OP_AUIPC: nxt.res = pc_plus_imm;
            OP_JAL: begin
                nxt.res    = pc_plus4;
                nxt.jump   = 1'b1;
                nxt.target = pc_plus_imm;
            end
            OP_JALR: begin
                nxt.res    = pc_plus4;
                nxt.jump   = 1'b1;
                nxt.target = (alu_val1 + alu_imm) & ~32'd1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                nxt.res    = 32'd0;
                nxt.jump   = br_taken;
                nxt.target = br_taken ? pc_plus_imm : pc_plus4;
            end
            OP_ADDI, OP_ADD:  nxt.res = alu_val1 + op2;
            OP_SUB:           nxt.res = alu_val1 - op2;
            OP_SLTI, OP_SLT:  nxt.res = {31'd0, $signed(alu_val1) < $signed(op2)};
            OP_SLTIU, OP_SLTU: nxt.res = {31'd0, alu_val1 < op2};
            OP_XORI, OP_XOR:  nxt.res = alu_val1 ^ op2;
            OP_ORI, OP_OR:    nxt.res = alu_val1 | op2;
            OP_ANDI, OP_AND:  nxt.res = alu_val1 & op2;
            OP_SLLI, OP_SLL:  nxt.res = alu_val1 << shamt;
            OP_SRLI, OP_SRL:  nxt.res = alu_val1 >> shamt;
            OP_SRAI, OP_SRA:  nxt.res = $unsigned($signed(alu_val1) >>> shamt);
            default:          nxt     = '0;
        endcase
    end

    // Output register: load on rdy, kill valid/jump on flush, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid         <= 1'b0;
            alu_res           <= 32'd0;
            alu_rob_index_out <= 6'd0;
            alu_jump          <= 1'b0;
            alu_target_pc     <= 32'd0;
        end else if (rdy) begin
            if (flush) begin
                alu_valid <= 1'b0;
                alu_jump  <= 1'b0;
            end else begin
                alu_valid         <= nxt.valid;
                alu_res           <= nxt.res;
                alu_rob_index_out <= alu_rob_index;
                alu_jump          <= nxt.jump;
                alu_target_pc     <= nxt.target;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for the integer ALU
module tb_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic [5:0]  alu_opcode = '0;
    logic [31:0] alu_val1 = '0;
    logic [31:0] alu_val2 = '0;
    logic [31:0] alu_imm = '0;
    logic [31:0] alu_pc = '0;
    logic [5:0]  alu_rob_index = '0;
    logic        alu_valid;
    logic [31:0] alu_res;
    logic [5:0]  alu_rob_index_out;
    logic        alu_jump;
    logic [31:0] alu_target_pc;

    int passed = 0;
    int total  = 0;

    // expected registered state
    logic        e_valid, e_jump;
    logic [31:0] e_res, e_target;
    logic [5:0]  e_rob;
    logic        e_care;   // res/rob/target/jump meaningful

    alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alu_opcode(alu_opcode), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_index(alu_rob_index),
        .alu_valid(alu_valid), .alu_res(alu_res),
        .alu_rob_index_out(alu_rob_index_out), .alu_jump(alu_jump),
        .alu_target_pc(alu_target_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Architectural reference: what an RV32I instruction produces.
    function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  output logic v, output logic [31:0] res,
                                  output logic j, output logic [31:0] t);
        logic [31:0] y;
        logic signed [31:0] sa, sy;
        bit cond;
        y = (op >= 11 && op <= 19) ? imm : b;
        sa = a; sy = y;
        v = (op >= 1 && op <= 29);
        res = 0; j = 0; t = 0;
        cond = 0;
        if (op == 1) res = imm;
        else if (op == 2) res = pc + imm;
        else if (op == 3) begin res = pc + 4; j = 1; t = pc + imm; end
        else if (op == 4) begin res = pc + 4; j = 1; t = (a + imm) & 32'hFFFF_FFFE; end
        else if (op >= 5 && op <= 10) begin
            case (op)
                5: cond = (a == b);
                6: cond = (a != b);
                7: cond = (sa < $signed(b));
                8: cond = !(sa < $signed(b));
                9: cond = (a < b);
                default: cond = !(a < b);
            endcase
            j = cond; t = cond ? pc + imm : pc + 4;
        end else begin
            case (op)
                11, 20: res = a + y;
                21: res = a - y;
                12, 23: res = (sa < sy) ? 1 : 0;
                13, 24: res = (a < y) ? 1 : 0;
                14, 25: res = a ^ y;
                15, 28: res = a | y;
                16, 29: res = a & y;
                17, 22: res = a * (32'd1 << y[4:0]);
                18, 26: res = a / (32'd1 << y[4:0]);
                19, 27: res = a[31] ? ~((~a) / (32'd1 << y[4:0])) : a / (32'd1 << y[4:0]);
                default: res = 0;
            endcase
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {31'd0, alu_valid}, {31'd0, e_valid});
        if (e_care) begin
            check({tag, ".res"}, alu_res, e_res);
            check({tag, ".rob"}, {26'd0, alu_rob_index_out}, {26'd0, e_rob});
            check({tag, ".target"}, alu_target_pc, e_target);
        end
        if (e_care || !e_jump) check({tag, ".jump"}, {31'd0, alu_jump}, {31'd0, e_jump});
    endtask

    // One clock: drive, update the expected state, clock, then compare.
    task automatic step(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] rob,
                        input logic r, input logic f);
        logic v, j;
        logic [31:0] res, t;
        alu_opcode = op[5:0]; alu_val1 = a; alu_val2 = b; alu_imm = imm;
        alu_pc = pc; alu_rob_index = rob; rdy = r; flush = f;
        model(op, a, b, imm, pc, v, res, j, t);
        if (r && f) begin
            e_valid = 0; e_jump = 0;
        end else if (r) begin
            e_valid = v; e_res = res; e_jump = j; e_target = t; e_rob = rob; e_care = v;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] a, b, imm, pc;
        int op;
        e_valid = 0; e_jump = 0; e_res = 0; e_target = 0; e_rob = 0; e_care = 1;

        #2 rst = 1'b1;
        #1 check_all("reset");
        @(negedge clk) rst = 1'b0;

        step("add", 20, 5, 7, 0, 0, 3, 1, 0);
        check("add_res12", alu_res, 32'd12);
        check("add_valid", {31'd0, alu_valid}, 32'd1);
        step("sub", 21, 0, 1, 0, 0, 4, 1, 0);
        check("sub_res", alu_res, 32'hFFFF_FFFF);
        step("srai", 19, 32'h8000_0000, 0, 4, 0, 5, 1, 0);
        check("srai_res", alu_res, 32'hF800_0000);
        step("blt", 7, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 6, 1, 0);
        check("blt_jump", {31'd0, alu_jump}, 32'd1);
        check("blt_target", alu_target_pc, 32'h120);
        step("bltu", 9, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 7, 1, 0);
        check("bltu_jump", {31'd0, alu_jump}, 32'd0);
        check("bltu_target", alu_target_pc, 32'h104);
        step("jalr", 4, 32'h1001, 0, 2, 32'h40, 8, 1, 0);
        check("jalr_res", alu_res, 32'h44);
        check("jalr_target", alu_target_pc, 32'h1002);

        // ADD, no-op, flushed ADD -> valid 1, 0, 0
        step("seq_add", 20, 1, 2, 0, 0, 9, 1, 0);
        check("seq_v0", {31'd0, alu_valid}, 32'd1);
        step("seq_nop", 0, 1, 2, 0, 0, 9, 1, 0);
        check("seq_v1", {31'd0, alu_valid}, 32'd0);
        step("seq_flush", 20, 1, 2, 0, 0, 9, 1, 1);
        check("seq_v2", {31'd0, alu_valid}, 32'd0);

        // stall for three cycles after a valid result
        step("jal", 3, 0, 0, 32'h10, 32'h200, 10, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 20, $urandom, $urandom, 0, 0, 11, 0, $urandom_range(0, 1));
            check("stall_res", alu_res, 32'h204);
            check("stall_valid", {31'd0, alu_valid}, 32'd1);
        end

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 35);
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            imm = $urandom; pc = $urandom & 32'hFFFF_FFFC;
            step("rand", op, a, b, imm, pc, 6'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
        end

        // asynchronous reset in the middle of traffic
        step("pre_rst", 1, 0, 0, 32'hABCD_0000, 0, 12, 1, 0);
        rst = 1'b1;
        #1;
        e_valid = 0; e_jump = 0; e_res = 0; e_target = 0; e_rob = 0; e_care = 1;
        check_all("async_rst");
        @(negedge clk) rst = 1'b0;
        step("post_rst", 20, 3, 4, 0, 0, 13, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
